// File: rtl/axil_native_bridge.sv
// AXI4-Lite slave to native register-bus bridge with independent write and read engines.
module axil_native_bridge #(
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_LO        = '0,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_HI        = {ADDR_WIDTH{1'b1}},
  parameter int unsigned            TIMEOUT_CYCLES = 256
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]     AXI_AWADDR,
  input  logic [2:0]                AXI_AWPROT,
  input  logic                      AXI_AWVALID,
  output logic                      AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   AXI_WSTRB,
  input  logic                      AXI_WVALID,
  output logic                      AXI_WREADY,
  output logic [1:0]                AXI_BRESP,
  output logic                      AXI_BVALID,
  input  logic                      AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]     AXI_ARADDR,
  input  logic [2:0]                AXI_ARPROT,
  input  logic                      AXI_ARVALID,
  output logic                      AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     AXI_RDATA,
  output logic [1:0]                AXI_RRESP,
  output logic                      AXI_RVALID,
  input  logic                      AXI_RREADY,
  output logic                      WEN,
  output logic [ADDR_WIDTH-1:0]     WADDR,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WACK,
  output logic                      REN,
  output logic [ADDR_WIDTH-1:0]     RADDR,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic                      RVALID
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_COLLECT, W_ISSUE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

  // Window check done with borrow bits so a zero or all-ones bound never folds into a constant compare.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] lo_diff;
    logic [ADDR_WIDTH:0] hi_diff;
    lo_diff = {1'b0, addr} - {1'b0, ADDR_LO};
    hi_diff = {1'b0, ADDR_HI} - {1'b0, addr};
    return !lo_diff[ADDR_WIDTH] && !hi_diff[ADDR_WIDTH];
  endfunction

  // Protection bits carry no meaning for this register bus.
  logic unused_prot;
  assign unused_prot = ^{AXI_AWPROT, AXI_ARPROT};

  // ---------------- write engine ----------------
  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic                  wr_ok_q, wr_ok_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wen_q, wen_d;
  logic                  wack_q, wack_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;

  // Write next-state: AW and W are captured independently straight into the native payload registers.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    wr_ok_d   = wr_ok_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wen_d     = 1'b0;
    wack_d    = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    unique case (w_state_q)
      W_COLLECT: begin
        if (AXI_AWVALID && awready_q) begin
          aw_held_d = 1'b1;
          waddr_d   = AXI_AWADDR;
        end
        if (AXI_WVALID && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = AXI_WDATA;
          wstrb_d  = AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_ISSUE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wr_ok_d   = in_range(waddr_d);
          wen_d     = wr_ok_d;
          bresp_d   = wr_ok_d ? RESP_OKAY : RESP_DECERR;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      W_ISSUE: begin
        w_state_d = W_RESP;
        bvalid_d  = 1'b1;
      end
      W_RESP: begin
        if (bvalid_q && AXI_BREADY) begin
          w_state_d = W_COLLECT;
          bvalid_d  = 1'b0;
          wack_d    = wr_ok_q;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  // Write state and output registers.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      w_state_q <= W_COLLECT;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      wr_ok_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      wen_q     <= 1'b0;
      wack_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      wr_ok_q   <= wr_ok_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wen_q     <= wen_d;
      wack_q    <= wack_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // ---------------- read engine ----------------
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  ren_q, ren_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Read next-state: native data takes priority over a timeout landing in the same cycle.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = 1'b0;
    ren_d     = 1'b0;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    cnt_d     = cnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (AXI_ARVALID && arready_q) begin
          if (in_range(AXI_ARADDR)) begin
            raddr_d   = AXI_ARADDR;
            ren_d     = 1'b1;
            cnt_d     = '0;
            r_state_d = R_WAIT;
          end else begin
            rvalid_d  = 1'b1;
            rresp_d   = RESP_DECERR;
            rdata_d   = '0;
            r_state_d = R_RESP;
          end
        end else begin
          arready_d = 1'b1;
        end
      end
      R_WAIT: begin
        if (RVALID) begin
          rvalid_d  = 1'b1;
          rresp_d   = RESP_OKAY;
          rdata_d   = RDATA;
          r_state_d = R_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES))) begin
          rvalid_d  = 1'b1;
          rresp_d   = RESP_SLVERR;
          rdata_d   = '0;
          r_state_d = R_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      R_RESP: begin
        if (rvalid_q && AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read state and output registers.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      ren_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      cnt_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      ren_q     <= ren_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign AXI_AWREADY = awready_q;
  assign AXI_WREADY  = wready_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_BRESP   = bresp_q;
  assign WEN         = wen_q;
  assign WACK        = wack_q;
  assign WADDR       = waddr_q;
  assign WDATA       = wdata_q;
  assign WSTRB       = wstrb_q;
  assign AXI_ARREADY = arready_q;
  assign REN         = ren_q;
  assign AXI_RVALID  = rvalid_q;
  assign AXI_RRESP   = rresp_q;
  assign AXI_RDATA   = rdata_q;
  assign RADDR       = raddr_q;

endmodule
